// File: rtl/intdst_agent.sv
// Interrupt-controller destination agent: acknowledges interrupts, delivers ids to the core, issues IPIs.
// Optional IPI busy-retry is built when INTDSTAGENT_IPIRETRY_EN is defined.
//
// state   | meaning
// IDLE    | arbitrating between interrupt ack, enable sync and IPI request
// ACK     | CMDACKINT in flight on PerInt
// DELIVER | source index presented to the core, waiting for irq_ready_i
// IPI     | CMDINTDST in flight (or waiting to retry after a busy response)
module intdst_agent #(
    parameter int ARCHBITSZ   = 32,
    parameter int DSTIDX      = 0,
    parameter int INTCTRLADDR = 0,
    localparam int ADDRBITSZ  = ARCHBITSZ - $clog2(ARCHBITSZ/8)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic [1:0]             pi1_op_o,
    output logic [ADDRBITSZ-1:0]   pi1_addr_o,
    output logic [ARCHBITSZ-1:0]   pi1_data_o,
    input  logic [ARCHBITSZ-1:0]   pi1_data_i,
    output logic [ARCHBITSZ/8-1:0] pi1_sel_o,
    input  logic                   pi1_rdy_i,
    input  logic                   intrqst_i,
    output logic                   intrdy_o,
    output logic                   intbest_o,
    input  logic                   en_i,
    input  logic                   halted_i,
    output logic                   irq_valid_o,
    output logic [ARCHBITSZ-1:0]   irq_id_o,
    input  logic                   irq_ready_i,
    input  logic                   ipi_req_i,
    input  logic [ARCHBITSZ-3:0]   ipi_dst_i,
    output logic                   ipi_done_o,
    output logic [ARCHBITSZ-1:0]   ipi_result_o
);

    localparam logic [1:0] PINOOP = 2'b00;
    localparam logic [1:0] PIRWOP = 2'b11;
    localparam logic [ARCHBITSZ-1:0] RESP_BUSY = {{(ARCHBITSZ-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {IDLE, ACK, DELIVER, IPI} state_t;

    state_t                 state_q, state_d;
    logic                   en_q;
    logic [ARCHBITSZ-1:0]   cmd_q;
    logic                   irq_valid_q;
    logic [ARCHBITSZ-1:0]   irq_id_q;
    logic                   ipi_done_q;
    logic [ARCHBITSZ-1:0]   ipi_result_q;
    logic                   launch_ack, launch_ipi, ack_fire, ipi_fire, op_active;
    logic                   resp_busy;
    logic [ARCHBITSZ-1:0]   ack_word, ipi_word;

`ifdef INTDSTAGENT_IPIRETRY_EN
    logic                   retry_wait_q;
    logic [3:0]             retry_cnt_q;
`endif

    assign ack_word  = (ARCHBITSZ'(DSTIDX) << 3) | {{(ARCHBITSZ-3){1'b0}}, en_i, 2'b00};
    assign ipi_word  = {ipi_dst_i, 2'b01};
    assign resp_busy = (pi1_data_i == RESP_BUSY);

    always_comb begin
        state_d    = state_q;
        launch_ack = 1'b0;
        launch_ipi = 1'b0;
        ack_fire   = 1'b0;
        ipi_fire   = 1'b0;
        op_active  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // ipi_done_q blocks a relaunch while the core is still dropping ipi_req_i
                if (intrqst_i || (en_i != en_q)) begin
                    state_d    = ACK;
                    launch_ack = 1'b1;
                end else if (ipi_req_i && !ipi_done_q) begin
                    state_d    = IPI;
                    launch_ipi = 1'b1;
                end
            end
            ACK: begin
                op_active = 1'b1;
                ack_fire  = pi1_rdy_i;
                if (pi1_rdy_i)
                    state_d = resp_busy ? IDLE : DELIVER;
            end
            DELIVER: begin
                if (irq_ready_i)
                    state_d = IDLE;
            end
            IPI: begin
`ifdef INTDSTAGENT_IPIRETRY_EN
                if (retry_wait_q) begin
                    if (intrqst_i)
                        state_d = IDLE;
                end else begin
                    op_active = 1'b1;
                    ipi_fire  = pi1_rdy_i;
                    if (pi1_rdy_i && !resp_busy)
                        state_d = IDLE;
                end
`else
                op_active = 1'b1;
                ipi_fire  = pi1_rdy_i;
                if (pi1_rdy_i)
                    state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            en_q         <= 1'b0;
            cmd_q        <= '0;
            irq_valid_q  <= 1'b0;
            irq_id_q     <= '0;
            ipi_done_q   <= 1'b0;
            ipi_result_q <= '0;
        end else begin
            state_q    <= state_d;
            ipi_done_q <= 1'b0;
            if (launch_ack) begin
                cmd_q <= ack_word;
                en_q  <= en_i;
            end
            if (launch_ipi)
                cmd_q <= ipi_word;
            if (ack_fire && !resp_busy) begin
                irq_id_q    <= pi1_data_i;
                irq_valid_q <= 1'b1;
            end
            if (state_q == DELIVER && irq_ready_i)
                irq_valid_q <= 1'b0;
`ifdef INTDSTAGENT_IPIRETRY_EN
            if (ipi_fire && !resp_busy) begin
`else
            if (ipi_fire) begin
`endif
                ipi_result_q <= pi1_data_i;
                ipi_done_q   <= 1'b1;
            end
        end
    end

`ifdef INTDSTAGENT_IPIRETRY_EN
    // Busy response: 16 quiet cycles in IPI, then reissue; the countdown freezes while an ACK runs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retry_wait_q <= 1'b0;
            retry_cnt_q  <= '0;
        end else if (ipi_fire && resp_busy) begin
            retry_wait_q <= 1'b1;
            retry_cnt_q  <= 4'd15;
        end else if (state_q == IPI && retry_wait_q) begin
            if (retry_cnt_q == 4'd0)
                retry_wait_q <= 1'b0;
            else
                retry_cnt_q <= retry_cnt_q - 4'd1;
        end else if (state_q == IDLE && !ipi_req_i) begin
            retry_wait_q <= 1'b0;
        end
    end
`endif

    assign pi1_op_o     = op_active ? PIRWOP : PINOOP;
    assign pi1_addr_o   = ADDRBITSZ'(INTCTRLADDR);
    assign pi1_data_o   = cmd_q;
    assign pi1_sel_o    = '1;
    assign intrdy_o     = (state_q == IDLE) && en_q && !irq_valid_q;
    assign intbest_o    = intrdy_o && halted_i;
    assign irq_valid_o  = irq_valid_q;
    assign irq_id_o     = irq_id_q;
    assign ipi_done_o   = ipi_done_q;
    assign ipi_result_o = ipi_result_q;

endmodule

// File: tb/tb_intdst_agent.sv
// Cycle-table bench for intdst_agent plus hand sequences for the IPI busy path.
// Retry-specific checks are compiled when INTDSTAGENT_IPIRETRY_EN is defined.
module tb_intdst_agent;
    localparam int AW    = 32;
    localparam int DST   = 1;       // ACK word with en=1 is then 0x0000000C
    localparam int CADDR = 'h40;
    localparam int ADW   = AW - $clog2(AW/8);

    logic            clk = 1'b0;
    logic            rst, rdy, rqst, en, halt, irdy, ipi;
    logic [AW-1:0]   pdin;
    logic [AW-3:0]   ipi_dst;
    logic [1:0]      op;
    logic [ADW-1:0]  addr;
    logic [AW-1:0]   dout, id, res;
    logic [AW/8-1:0] sel;
    logic            intrdy, best, vld, done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    intdst_agent #(.ARCHBITSZ(AW), .DSTIDX(DST), .INTCTRLADDR(CADDR)) dut (
        .clk_i(clk), .rst_i(rst),
        .pi1_op_o(op), .pi1_addr_o(addr), .pi1_data_o(dout), .pi1_data_i(pdin),
        .pi1_sel_o(sel), .pi1_rdy_i(rdy),
        .intrqst_i(rqst), .intrdy_o(intrdy), .intbest_o(best),
        .en_i(en), .halted_i(halt),
        .irq_valid_o(vld), .irq_id_o(id), .irq_ready_i(irdy),
        .ipi_req_i(ipi), .ipi_dst_i(ipi_dst), .ipi_done_o(done), .ipi_result_o(res)
    );

    // f = {rst, intrqst, en, halted, irq_ready, ipi_req}; e = {intrdy, intbest, irq_valid}
    typedef struct {
        logic [5:0]  f;
        logic [7:0]  dst;
        logic        prdy;
        logic [31:0] pd;
        logic [1:0]  op;
        logic [31:0] dout;
        logic [2:0]  e;
        logic [31:0] id;
        logic        done;
        logic [31:0] res;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input logic [5:0] f, input logic [7:0] dst, input logic prdy,
                     input logic [31:0] pd, input logic [1:0] xop, input logic [31:0] xdout,
                     input logic [2:0] e, input logic [31:0] xid, input logic xdone,
                     input logic [31:0] xres);
        vec_t t;
        t.f = f; t.dst = dst; t.prdy = prdy; t.pd = pd; t.op = xop; t.dout = xdout;
        t.e = e; t.id = xid; t.done = xdone; t.res = xres;
        tbl.push_back(t);
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic idle_inputs();
        rst = 0; rqst = 0; en = 0; halt = 0; irdy = 0; ipi = 0;
        ipi_dst = '0; rdy = 1; pdin = '0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    localparam logic [31:0] M1 = 32'hFFFF_FFFF;
    localparam logic [31:0] M2 = 32'hFFFF_FFFE;

    initial begin
        idle_inputs();
        rst = 1;
        @(negedge clk);
        step();

        //  flags     dst prdy pdata         op dout     e     id  done res
        v(6'b100000, 0, 1, 0,              0, 32'h0, 3'b000, 0, 0, 0);
        v(6'b001000, 0, 1, 0,              0, 32'h0, 3'b000, 0, 0, 0);
        v(6'b001000, 0, 1, M2,             3, 32'hC, 3'b000, 0, 0, 0);
        v(6'b001000, 0, 1, 0,              0, 32'hC, 3'b100, 0, 0, 0);
        v(6'b001100, 0, 1, 0,              0, 32'hC, 3'b110, 0, 0, 0);
        v(6'b011000, 0, 1, 0,              0, 32'hC, 3'b100, 0, 0, 0);
        v(6'b011000, 0, 0, 32'h55,         3, 32'hC, 3'b000, 0, 0, 0);
        v(6'b011000, 0, 0, 32'h55,         3, 32'hC, 3'b000, 0, 0, 0);
        v(6'b011000, 0, 0, 32'h55,         3, 32'hC, 3'b000, 0, 0, 0);
        v(6'b011000, 0, 1, 32'h5,          3, 32'hC, 3'b000, 0, 0, 0);
        v(6'b011100, 0, 1, 32'h77,         0, 32'hC, 3'b001, 5, 0, 0);
        v(6'b011000, 0, 1, 32'h99,         0, 32'hC, 3'b001, 5, 0, 0);
        v(6'b001010, 0, 1, 0,              0, 32'hC, 3'b001, 5, 0, 0);
        v(6'b001000, 0, 1, 0,              0, 32'hC, 3'b100, 5, 0, 0);
        v(6'b001001, 1, 1, 0,              0, 32'hC, 3'b100, 5, 0, 0);
        v(6'b001001, 1, 1, 32'h1,          3, 32'h5, 3'b000, 5, 0, 0);
        v(6'b001001, 1, 1, 0,              0, 32'h5, 3'b100, 5, 1, 1);
        v(6'b001000, 0, 1, 0,              0, 32'h5, 3'b100, 5, 0, 1);
        v(6'b001001, 3, 1, 0,              0, 32'h5, 3'b100, 5, 0, 1);
        v(6'b001001, 3, 1, M1,             3, 32'hD, 3'b000, 5, 0, 1);
        v(6'b001001, 3, 1, 0,              0, 32'hD, 3'b100, 5, 1, M1);
        v(6'b001000, 0, 1, 0,              0, 32'hD, 3'b100, 5, 0, M1);
        v(6'b011001, 2, 1, 0,              0, 32'hD, 3'b100, 5, 0, M1);
        v(6'b011001, 2, 1, 32'h7,          3, 32'hC, 3'b000, 5, 0, M1);
        v(6'b001001, 2, 1, 0,              0, 32'hC, 3'b001, 7, 0, M1);
        v(6'b001011, 2, 1, 0,              0, 32'hC, 3'b001, 7, 0, M1);
        v(6'b001001, 2, 1, 0,              0, 32'hC, 3'b100, 7, 0, M1);
        v(6'b001001, 2, 1, 32'h2,          3, 32'h9, 3'b000, 7, 0, M1);
        v(6'b001001, 2, 1, 0,              0, 32'h9, 3'b100, 7, 1, 2);
        v(6'b001000, 0, 1, 0,              0, 32'h9, 3'b100, 7, 0, 2);
        v(6'b011000, 0, 1, 0,              0, 32'h9, 3'b100, 7, 0, 2);
        v(6'b011000, 0, 1, 32'h4,          3, 32'hC, 3'b000, 7, 0, 2);
        v(6'b000000, 0, 1, 0,              0, 32'hC, 3'b001, 4, 0, 2);
        v(6'b000010, 0, 1, 0,              0, 32'hC, 3'b001, 4, 0, 2);
        v(6'b000000, 0, 1, 0,              0, 32'hC, 3'b100, 4, 0, 2);
        v(6'b000000, 0, 1, M2,             3, 32'h8, 3'b000, 4, 0, 2);
        v(6'b000000, 0, 1, 0,              0, 32'h8, 3'b000, 4, 0, 2);
        v(6'b001000, 0, 1, 0,              0, 32'h8, 3'b000, 4, 0, 2);
        v(6'b001000, 0, 0, 0,              3, 32'hC, 3'b000, 4, 0, 2);
        v(6'b101000, 0, 0, 0,              3, 32'hC, 3'b000, 4, 0, 2);
        v(6'b000000, 0, 1, 0,              0, 32'h0, 3'b000, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            {rst, rqst, en, halt, irdy, ipi} = tbl[i].f;
            ipi_dst = 30'(tbl[i].dst);
            rdy     = tbl[i].prdy;
            pdin    = tbl[i].pd;
            #1;
            check($sformatf("vec%0d", i),
                  128'({op, dout, intrdy, best, vld, id, done, res}),
                  128'({tbl[i].op, tbl[i].dout, tbl[i].e, tbl[i].id, tbl[i].done, tbl[i].res}));
            step();
        end

        idle_inputs();
        #1;
        check("pi1_addr_o", 128'(addr), 128'(ADW'(CADDR)));
        check("pi1_sel_o", 128'(sel), 128'(4'hF));
        step();

`ifdef INTDSTAGENT_IPIRETRY_EN
        begin
            int op_cyc[$];
            int n_done = 0;
            logic [31:0] last_res = '0;
            ipi = 1; ipi_dst = 30'd3;
            for (int c = 0; c < 200 && n_done == 0; c++) begin
                pdin = (op_cyc.size() < 2) ? M2 : 32'h3;
                #1;
                if (op == 2'b11) op_cyc.push_back(c);
                if (done) begin
                    n_done++;
                    last_res = res;
                end
                step();
            end
            ipi = 0;
            for (int c = 0; c < 20; c++) begin
                #1;
                if (done) n_done++;
                step();
            end
            check("retry_op_count", 128'(op_cyc.size()), 128'(3));
            if (op_cyc.size() == 3) begin
                check("retry_gap1", 128'(op_cyc[1] - op_cyc[0]), 128'(17));
                check("retry_gap2", 128'(op_cyc[2] - op_cyc[1]), 128'(17));
            end
            check("retry_done_count", 128'(n_done), 128'(1));
            check("retry_result", 128'(last_res), 128'(3));
        end
`else
        begin
            int seen = 0;
            ipi = 1; ipi_dst = 30'd6; pdin = M2;
            for (int c = 0; c < 10 && seen == 0; c++) begin
                #1;
                if (op == 2'b11) seen = 1;
                step();
            end
            check("busy_ipi_issued", 128'(seen), 128'(1));
            #1;
            check("busy_ipi_done", 128'({done, res}), 128'({1'b1, M2}));
            step();
            ipi = 0;
            #1;
            check("busy_ipi_pulse_end", 128'(done), 128'(0));
            step();
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end
endmodule
